// File: rtl/parallel_fifo.sv
// Ready/valid FIFO with DEPTH-entry register storage, flush, occupancy count and almost-full flag.
// Ready is granted on a full FIFO when the consumer drains in the same cycle, giving one word per clock.
module parallel_fifo #(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 4,
    parameter int ALMOST_FULL = DEPTH - 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       write_in,
    output logic                       write_ready,
    output logic [WIDTH-1:0]           data_out,
    output logic                       write_out,
    input  logic                       next_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(ALMOST_FULL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    assign write_out   = (count != '0);
    assign data_out    = mem[rd_ptr];
    assign write_ready = !flush && ((count < DEPTH_C) || next_ready);
    assign almost_full = (count >= AF_C);
    assign pop         = write_out && next_ready;
    assign push        = write_in && write_ready;

    // Control state: pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is never cleared; a full FIFO writes into the slot its pop frees this edge
    always_ff @(posedge clock) begin
        if (push && !reset) mem[wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_parallel_fifo.sv
// Directed bench for parallel_fifo: fill, drain, full-rate streaming, flush, reset and a two-stage chain.
module tb_parallel_fifo;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       write_in = 1'b0;
    logic       write_ready;
    logic [7:0] data_out;
    logic       write_out;
    logic       next_ready = 1'b0;
    logic [2:0] count;
    logic       almost_full;

    logic [7:0] c_data_in = 8'h00;
    logic       c_write_in = 1'b0;
    logic       c_write_ready;
    logic [7:0] c_mid_data;
    logic       c_mid_valid;
    logic       c_mid_ready;
    logic [2:0] c_a_count;
    logic       c_a_af;
    logic [7:0] c_data_out;
    logic       c_write_out;
    logic       c_next_ready = 1'b0;
    logic [2:0] c_b_count;
    logic       c_b_af;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    parallel_fifo #(.WIDTH(8), .DEPTH(4), .ALMOST_FULL(3)) dut (
        .clock(clock), .reset(reset), .flush(flush), .data_in(data_in),
        .write_in(write_in), .write_ready(write_ready), .data_out(data_out),
        .write_out(write_out), .next_ready(next_ready), .count(count),
        .almost_full(almost_full)
    );

    parallel_fifo #(.WIDTH(8), .DEPTH(4), .ALMOST_FULL(3)) u_chain_a (
        .clock(clock), .reset(reset), .flush(1'b0), .data_in(c_data_in),
        .write_in(c_write_in), .write_ready(c_write_ready), .data_out(c_mid_data),
        .write_out(c_mid_valid), .next_ready(c_mid_ready), .count(c_a_count),
        .almost_full(c_a_af)
    );

    parallel_fifo #(.WIDTH(8), .DEPTH(4), .ALMOST_FULL(3)) u_chain_b (
        .clock(clock), .reset(reset), .flush(1'b0), .data_in(c_mid_data),
        .write_in(c_mid_valid), .write_ready(c_mid_ready), .data_out(c_data_out),
        .write_out(c_write_out), .next_ready(c_next_ready), .count(c_b_count),
        .almost_full(c_b_af)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        data_in  = d;
        write_in = 1'b1;
        tick();
        write_in = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_tests++; if (write_out !== 1'b0) begin n_fail++; $display("FAIL reset_write_out: got %0b expected 0", write_out); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
        n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost_full: got %0b expected 0", almost_full); end
        n_tests++; if (write_ready !== 1'b1) begin n_fail++; $display("FAIL reset_write_ready: got %0b expected 1", write_ready); end
    endtask

    task automatic test_fill();
        next_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in  = 8'(8'h11 * (i + 1));
            write_in = 1'b1;
            #1;
            n_tests++; if (write_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d]: got %0b expected 1", i, write_ready); end
            tick();
            n_tests++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i + 1); end
            n_tests++; if (almost_full !== ((i + 1) >= 3)) begin n_fail++; $display("FAIL fill_af[%0d]: got %0b expected %0b", i, almost_full, (i + 1) >= 3); end
            n_tests++; if (data_out !== 8'h11) begin n_fail++; $display("FAIL fill_head[%0d]: got %0h expected 11", i, data_out); end
        end
        data_in = 8'h55;
        #1;
        n_tests++; if (write_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b expected 0", write_ready); end
        tick();
        write_in = 1'b0;
        n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d expected 4", count); end
        n_tests++; if (data_out !== 8'h11) begin n_fail++; $display("FAIL full_head: got %0h expected 11", data_out); end
    endtask

    task automatic test_drain();
        logic [7:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        next_ready = 1'b1;
        write_in   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (data_out !== exp_d[i]) begin n_fail++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, data_out, exp_d[i]); end
            n_tests++; if (count !== 3'(4 - i)) begin n_fail++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, 4 - i); end
            tick();
        end
        next_ready = 1'b0;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_end_count: got %0d expected 0", count); end
        n_tests++; if (write_out !== 1'b0) begin n_fail++; $display("FAIL drain_end_valid: got %0b expected 0", write_out); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_d [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h50, 8'h51, 8'h52, 8'h53};
        logic [7:0] exp_t [4] = '{8'h54, 8'h55, 8'h56, 8'h57};
        push_word(8'h11); push_word(8'h22); push_word(8'h33); push_word(8'h44);
        write_in   = 1'b1;
        next_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(8'h50 + i);
            #1;
            n_tests++; if (write_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %0b expected 1", i, write_ready); end
            n_tests++; if (data_out !== exp_d[i]) begin n_fail++; $display("FAIL b2b_data[%0d]: got %0h expected %0h", i, data_out, exp_d[i]); end
            tick();
            n_tests++; if (count !== 3'd4) begin n_fail++; $display("FAIL b2b_count[%0d]: got %0d expected 4", i, count); end
        end
        write_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++; if (data_out !== exp_t[i]) begin n_fail++; $display("FAIL b2b_tail[%0d]: got %0h expected %0h", i, data_out, exp_t[i]); end
            tick();
        end
        next_ready = 1'b0;
        n_tests++; if (write_out !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %0b expected 0", write_out); end
    endtask

    task automatic test_empty_simultaneous();
        data_in    = 8'hA5;
        write_in   = 1'b1;
        next_ready = 1'b1;
        #1;
        n_tests++; if (write_ready !== 1'b1) begin n_fail++; $display("FAIL sim_ready: got %0b expected 1", write_ready); end
        tick();
        write_in = 1'b0;
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL sim_count: got %0d expected 1", count); end
        n_tests++; if (write_out !== 1'b1) begin n_fail++; $display("FAIL sim_valid: got %0b expected 1", write_out); end
        n_tests++; if (data_out !== 8'hA5) begin n_fail++; $display("FAIL sim_data: got %0h expected a5", data_out); end
        tick();
        next_ready = 1'b0;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL sim_pop_count: got %0d expected 0", count); end
    endtask

    task automatic test_flush();
        push_word(8'h61); push_word(8'h62); push_word(8'h63);
        n_tests++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
        flush    = 1'b1;
        write_in = 1'b1;
        data_in  = 8'hEE;
        #1;
        n_tests++; if (write_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %0b expected 0", write_ready); end
        tick();
        flush    = 1'b0;
        write_in = 1'b0;
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d expected 0", count); end
        n_tests++; if (write_out !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %0b expected 0", write_out); end
        push_word(8'h01);
        n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL flush_post_count: got %0d expected 1", count); end
        n_tests++; if (data_out !== 8'h01) begin n_fail++; $display("FAIL flush_post_head: got %0h expected 01", data_out); end
    endtask

    task automatic test_reset_midstream();
        push_word(8'h02);
        n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL mid_pre_count: got %0d expected 2", count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        n_tests++; if (write_out !== 1'b0) begin n_fail++; $display("FAIL mid_valid: got %0b expected 0", write_out); end
        n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count: got %0d expected 0", count); end
        n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL mid_af: got %0b expected 0", almost_full); end
        n_tests++; if (write_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %0b expected 1", write_ready); end
        push_word(8'h3C);
        n_tests++; if (data_out !== 8'h3C) begin n_fail++; $display("FAIL mid_post_head: got %0h expected 3c", data_out); end
    endtask

    task automatic test_chain();
        int tx = 0;
        int rx = 0;
        logic accepted;
        c_data_in  = 8'h01;
        c_write_in = 1'b1;
        for (int cyc = 0; cyc < 100 && rx < 8; cyc++) begin
            c_next_ready = cyc[0];
            #1;
            accepted = c_write_in && c_write_ready;
            if (c_write_out && c_next_ready) begin
                n_tests++;
                if (c_data_out !== 8'(rx + 1)) begin n_fail++; $display("FAIL chain_data[%0d]: got %0h expected %0h", rx, c_data_out, rx + 1); end
                rx++;
            end
            tick();
            if (accepted) begin
                tx++;
                if (tx < 8) c_data_in = 8'(tx + 1);
                else c_write_in = 1'b0;
            end
        end
        c_next_ready = 1'b0;
        n_tests++; if (rx !== 8) begin n_fail++; $display("FAIL chain_received: got %0d expected 8", rx); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_empty_simultaneous();
        test_flush();
        test_reset_midstream();
        test_chain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/parallel_fifo.md
Name: parallel_fifo

Overview:
- Parametrised, multi-entry successor to the single-slot parallel buffer.
- Ready/valid FIFO between a producer and a consumer; keeps the existing handshake names (write_in/write_ready upstream, write_out/next_ready downstream) so it drops into existing buffer chains.
- Adds DEPTH-entry storage, synchronous reset, flush, occupancy count and almost-full flag, and full-rate throughput when full.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of entries; power of two, 2 to 256.
- ALMOST_FULL, DEPTH-1, count threshold at or above which almost_full asserts; 1 to DEPTH.

Ports:
- clock  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- flush  in  1  synchronous, active-high; discards contents.
- data_in  in  WIDTH  write data, sampled when push occurs.
- write_in  in  1  producer has valid data_in.
- write_ready  out  1  FIFO accepts data_in on this edge.
- data_out  out  WIDTH  head entry.
- write_out  out  1  data_out is valid (FIFO not empty).
- next_ready  in  1  consumer takes data_out on this edge.
- count  out  $clog2(DEPTH+1)  current occupancy, 0 to DEPTH.
- almost_full  out  1  count >= ALMOST_FULL.

Behaviour:
- Storage: DEPTH x WIDTH register array, with read and write pointers of $clog2(DEPTH) bits and a separate count register. Pointers wrap modulo DEPTH.
- Combinational outputs:
  - write_out = (count != 0).
  - data_out = mem[rd_ptr], combinational from storage. When count == 0, data_out is don't-care; the bench must not check it.
  - write_ready = !flush && ((count < DEPTH) || next_ready). When full, the FIFO is ready in the same cycle the consumer drains, so a full FIFO with next_ready held high sustains one word per clock.
  - almost_full = (count >= ALMOST_FULL).
- Events per edge:
  - pop = write_out && next_ready.
  - push = write_in && write_ready.
- Updates on each rising edge, in priority order:
  1. reset: rd_ptr = wr_ptr = count = 0. Resulting outputs: write_out=0, write_ready=1 (flush low), count=0, almost_full=0 (ALMOST_FULL >= 1). Storage contents are not cleared.
  2. flush: same clearing as reset. Any push or pop in that cycle is ignored; write_ready is already 0, so the producer sees no acceptance.
  3. Normal operation:
     - push: mem[wr_ptr] = data_in; wr_ptr++.
     - pop: rd_ptr++.
     - count += push - pop. Simultaneous push and pop leaves count unchanged.
- Latency:
  - A word pushed into an empty FIFO appears on data_out with write_out=1 after that same edge (1-cycle latency). No combinational bypass from data_in to data_out.
  - Order is strictly FIFO; no word is dropped or duplicated.
- Boundary conditions:
  - Empty: pop is impossible because write_out=0; next_ready is ignored.
  - Empty with simultaneous write_in and next_ready: push only; count goes 0 to 1.
  - Full with next_ready=0: write_ready=0; write_in is ignored and data_in is not stored.
  - Full with next_ready=1 and write_in=1: push and pop together; count stays DEPTH; the new word goes into the slot just freed.
  - Wrap-around: pointers roll from DEPTH-1 to 0 with no gap or bubble.
  - Reset or flush mid-stream: all buffered words are lost. The next push after deassertion lands at index 0 and is the next word output.
- Chaining: two instances back-to-back behave as one FIFO of 2*DEPTH, with one extra cycle of latency.

Test Plan:
1. WIDTH=8, DEPTH=4. Reset, then push 0x11,0x22,0x33,0x44 on consecutive cycles with next_ready=0 -> count goes 1,2,3,4; almost_full=1 at count 3; write_ready=0 at count 4; a 5th write of 0x55 is not stored.
2. From full, raise next_ready for 4 cycles with write_in=0 -> data_out reads 0x11,0x22,0x33,0x44 in order; count 4,3,2,1,0; write_out=0 afterwards.
3. Full, with write_in=1 and next_ready=1 held for 8 cycles while data_in increments 0x50..0x57 -> write_ready=1 throughout; count stays 4; outputs 0x11..0x44 then 0x50..0x53; pointers wrap twice.
4. Empty FIFO, write_in=1 with data 0xA5 and next_ready=1 at the same edge -> count=1; write_out=1 and data_out=0xA5 after the edge; popped on the following edge.
5. Count=3, assert flush together with write_in=1 (0xEE) -> write_ready=0 during flush; count=0 and write_out=0 after the edge; the next push of 0x01 appears as the head.
6. Count=2, assert reset for one cycle -> write_out=0, count=0, almost_full=0, write_ready=1; then two chained instances pass 0x01..0x08 in order with next_ready toggling every cycle.
